// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch port.
//   imu_addr  : fetch address driven by the fetch unit
//   imu_dout  : instruction word for imu_addr, valid in the same cycle
//   imu_error : imu_addr lies outside the user/interrupt program regions
// master = fetch unit (initiator), slave = instruction memory unit.
interface if_fetch_unit_if;
  logic [15:0] imu_addr;
  logic [31:0] imu_dout;
  logic        imu_error;

  modport master (
    output imu_addr,
    input  imu_dout,
    input  imu_error
  );

  modport slave (
    input  imu_addr,
    output imu_dout,
    output imu_error
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit of the RISC-V core.
// Holds the PC, presents it as the fetch address on the instruction memory
// port, and captures the returned word into the IF/ID register. It also
// handles branch redirects, interrupt entry/return, fetch-address faults and
// debug halt / single-step.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   imu (master)          : imu_addr out, imu_dout / imu_error in
//   stall                 : decode not ready, hold PC and IF/ID
//   br_valid, br_target   : redirect request and address
//   mret                  : return from interrupt program
//   irq, irq_ack          : level interrupt request, one-cycle entry pulse
//   epc, in_handler       : saved return PC, interrupt program active
//   if_valid/if_pc/if_inst: IF/ID register towards decode
//   fetch_fault, fault_pc : sticky fault flag and faulting address
//   halt, step, halted    : debug halt request, single-step, halted status
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h3000,
  parameter logic [15:0] IRQ_VECTOR = 16'hF000,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  if_fetch_unit_if.master       imu,
  input  logic                  stall,
  input  logic                  br_valid,
  input  logic [15:0]           br_target,
  input  logic                  mret,
  input  logic                  irq,
  output logic                  irq_ack,
  output logic [15:0]           epc,
  output logic                  in_handler,
  output logic                  if_valid,
  output logic [15:0]           if_pc,
  output logic [31:0]           if_inst,
  output logic                  fetch_fault,
  output logic [15:0]           fault_pc,
  input  logic                  halt,
  input  logic                  step,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_seq;

  assign imu.imu_addr = pc;
  // 16-bit add wraps naturally from FFFC to 0000.
  assign pc_seq = pc + 16'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_pc       <= 16'h0000;
      epc         <= 16'h0000;
      in_handler  <= 1'b0;
      irq_ack     <= 1'b0;
      fetch_fault <= 1'b0;
      fault_pc    <= 16'h0000;
      halted      <= 1'b0;
    end else begin
      irq_ack <= 1'b0;
      unique case (state)
        ST_RUN: begin
          // Control-flow events override stall: decode flushes on them.
          if (br_valid) begin
            pc       <= br_target;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end else if (mret) begin
            pc         <= epc;
            in_handler <= 1'b0;
            if_valid   <= 1'b0;
            if_inst    <= NOP_INST;
          end else if (irq && !in_handler) begin
            epc        <= pc;
            pc         <= IRQ_VECTOR;
            in_handler <= 1'b1;
            irq_ack    <= 1'b1;
            if_valid   <= 1'b0;
            if_inst    <= NOP_INST;
          end else if (stall) begin
            // hold PC and IF/ID
          end else if (imu.imu_error) begin
            state       <= ST_FAULT;
            fetch_fault <= 1'b1;
            fault_pc    <= pc;
            if_valid    <= 1'b0;
            if_inst     <= NOP_INST;
          end else if (halt) begin
            state    <= ST_HALT;
            halted   <= 1'b1;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end else begin
            if_inst  <= imu.imu_dout;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc_seq;
          end
        end

        ST_HALT: begin
          // Redirects and interrupts are ignored while halted. Any cycle that
          // is not a single-step issues a bubble, so a stepped instruction is
          // visible to decode for exactly one cycle.
          if (!halt) begin
            state    <= ST_RUN;
            halted   <= 1'b0;
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end else if (step && !stall) begin
            if (imu.imu_error) begin
              state       <= ST_FAULT;
              halted      <= 1'b0;
              fetch_fault <= 1'b1;
              fault_pc    <= pc;
              if_valid    <= 1'b0;
              if_inst     <= NOP_INST;
            end else begin
              if_inst  <= imu.imu_dout;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc_seq;
            end
          end else begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
          end
        end

        ST_FAULT: begin
          // PC frozen; only an interrupt can leave this state. The fault
          // flag stays set until reset so software can inspect it.
          if_valid <= 1'b0;
          if_inst  <= NOP_INST;
          if (irq && !in_handler) begin
            epc        <= fault_pc;
            pc         <= IRQ_VECTOR;
            in_handler <= 1'b1;
            irq_ack    <= 1'b1;
            state      <= ST_RUN;
          end
        end

        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: scenario tasks drive stimulus and check
// control outputs inline; every expected IF/ID instruction is pushed to a
// scoreboard queue before its clock edge and popped by a monitor after it.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, br_valid, mret, irq, halt, step, err_drv;
  logic [15:0] br_target;
  logic        irq_ack, in_handler, if_valid, fetch_fault, halted;
  logic [15:0] epc, if_pc, fault_pc;
  logic [31:0] if_inst;
  logic        use_fixed;
  logic [31:0] fixed_word;

  if_fetch_unit_if bus();

  // Memory model: either an explicit word or a pattern derived from the address.
  assign bus.imu_dout  = use_fixed ? fixed_word : {16'hA5A5, bus.imu_addr};
  assign bus.imu_error = err_drv;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .imu(bus),
    .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .mret(mret), .irq(irq), .irq_ack(irq_ack), .epc(epc),
    .in_handler(in_handler), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .fetch_fault(fetch_fault), .fault_pc(fault_pc),
    .halt(halt), .step(step), .halted(halted)
  );

  int          total = 0;
  int          bad   = 0;
  logic [47:0] sb[$];
  logic [47:0] sb_exp;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] mw(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  task automatic push(input logic [15:0] p, input logic [31:0] w);
    sb.push_back({p, w});
  endtask

  // Inputs change and checks happen at posedge+2; the monitor runs at posedge+1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      total++;
      if (sb.size() > 0) begin
        sb_exp = sb.pop_front();
        if (if_valid !== 1'b1 || if_pc !== sb_exp[47:32] || if_inst !== sb_exp[31:0]) begin
          bad++;
          $display("FAIL sb_fetch: got valid=%b pc=%h inst=%h, want valid=1 pc=%h inst=%h",
                   if_valid, if_pc, if_inst, sb_exp[47:32], sb_exp[31:0]);
        end
      end else if (if_valid !== 1'b0 || if_inst !== NOP) begin
        bad++;
        $display("FAIL sb_bubble: got valid=%b inst=%h, want valid=0 inst=%h", if_valid, if_inst, NOP);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++;
    if (bus.imu_addr !== 16'h3000 || if_valid !== 1'b0 || if_inst !== NOP || if_pc !== 16'h0) begin
      bad++;
      $display("FAIL reset_fetch: addr=%h valid=%b inst=%h pc=%h, want 3000 0 %h 0000", bus.imu_addr, if_valid, if_inst, NOP, if_pc);
    end
    total++;
    if (epc !== 16'h0 || in_handler !== 1'b0 || irq_ack !== 1'b0 || fetch_fault !== 1'b0 || fault_pc !== 16'h0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: epc=%h inh=%b ack=%b ff=%b fpc=%h halted=%b, want all zero", epc, in_handler, irq_ack, fetch_fault, fault_pc, halted);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_run();
    logic [31:0] words[3];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    rst = 1'b0; use_fixed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fixed_word = words[i];
      push(16'h3000 + 16'(4 * i), words[i]);
      tick();
      total++;
      if (bus.imu_addr !== 16'h3004 + 16'(4 * i)) begin
        bad++;
        $display("FAIL run_addr%0d: got %h want %h", i, bus.imu_addr, 16'h3004 + 16'(4 * i));
      end
    end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(16'h3008, 32'hC);
      tick();
      total++;
      if (bus.imu_addr !== 16'h300C) begin
        bad++;
        $display("FAIL stall_hold%0d: addr got %h want 300c", i, bus.imu_addr);
      end
    end
    br_valid = 1'b1; br_target = 16'h3100;
    tick();
    br_valid = 1'b0; stall = 1'b0; use_fixed = 1'b0;
    total++;
    if (bus.imu_addr !== 16'h3100 || if_pc !== 16'h3008) begin
      bad++;
      $display("FAIL stall_redirect: addr=%h if_pc=%h, want 3100 3008", bus.imu_addr, if_pc);
    end
    push(16'h3100, mw(16'h3100));
    tick();
    total++;
    if (bus.imu_addr !== 16'h3104) begin
      bad++;
      $display("FAIL redirect_adv: addr got %h want 3104", bus.imu_addr);
    end
  endtask

  task automatic test_irq();
    br_valid = 1'b1; br_target = 16'h300C;
    tick();
    br_valid = 1'b0; irq = 1'b1;
    tick();
    total++;
    if (irq_ack !== 1'b1 || epc !== 16'h300C || bus.imu_addr !== 16'hF000 || in_handler !== 1'b1) begin
      bad++;
      $display("FAIL irq_entry: ack=%b epc=%h addr=%h inh=%b, want 1 300c f000 1", irq_ack, epc, bus.imu_addr, in_handler);
    end
    push(16'hF000, mw(16'hF000));
    tick();
    total++;
    if (irq_ack !== 1'b0 || bus.imu_addr !== 16'hF004 || epc !== 16'h300C || in_handler !== 1'b1) begin
      bad++;
      $display("FAIL irq_masked: ack=%b addr=%h epc=%h inh=%b, want 0 f004 300c 1", irq_ack, bus.imu_addr, epc, in_handler);
    end
    irq = 1'b0; mret = 1'b1;
    tick();
    total++;
    if (bus.imu_addr !== 16'h300C || in_handler !== 1'b0) begin
      bad++;
      $display("FAIL mret: addr=%h inh=%b, want 300c 0", bus.imu_addr, in_handler);
    end
    mret = 1'b0; irq = 1'b1;
    tick();
    mret = 1'b1;
    tick();
    total++;
    if (bus.imu_addr !== 16'h300C || in_handler !== 1'b0 || irq_ack !== 1'b0) begin
      bad++;
      $display("FAIL mret_irq_same: addr=%h inh=%b ack=%b, want 300c 0 0", bus.imu_addr, in_handler, irq_ack);
    end
    mret = 1'b0;
    tick();
    total++;
    if (irq_ack !== 1'b1 || bus.imu_addr !== 16'hF000 || epc !== 16'h300C) begin
      bad++;
      $display("FAIL irq_after_mret: ack=%b addr=%h epc=%h, want 1 f000 300c", irq_ack, bus.imu_addr, epc);
    end
    irq = 1'b0; mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  task automatic test_fault();
    br_valid = 1'b1; br_target = 16'h2000;
    tick();
    br_valid = 1'b0; err_drv = 1'b1;
    tick();
    err_drv = 1'b0;
    total++;
    if (fetch_fault !== 1'b1 || fault_pc !== 16'h2000 || bus.imu_addr !== 16'h2000) begin
      bad++;
      $display("FAIL fault_entry: ff=%b fpc=%h addr=%h, want 1 2000 2000", fetch_fault, fault_pc, bus.imu_addr);
    end
    br_valid = 1'b1; br_target = 16'h1234;
    tick();
    br_valid = 1'b0;
    total++;
    if (bus.imu_addr !== 16'h2000 || fetch_fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_br_ignored: addr=%h ff=%b, want 2000 1", bus.imu_addr, fetch_fault);
    end
    irq = 1'b1;
    tick();
    irq = 1'b0;
    total++;
    if (epc !== 16'h2000 || bus.imu_addr !== 16'hF000 || irq_ack !== 1'b1 || fetch_fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_irq: epc=%h addr=%h ack=%b ff=%b, want 2000 f000 1 1", epc, bus.imu_addr, irq_ack, fetch_fault);
    end
    push(16'hF000, mw(16'hF000));
    tick();
    total++;
    if (bus.imu_addr !== 16'hF004 || fetch_fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_sticky: addr=%h ff=%b, want f004 1", bus.imu_addr, fetch_fault);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (fetch_fault !== 1'b0 || fault_pc !== 16'h0 || bus.imu_addr !== 16'h3000 || in_handler !== 1'b0 || epc !== 16'h0) begin
      bad++;
      $display("FAIL fault_reset: ff=%b fpc=%h addr=%h inh=%b epc=%h, want 0 0000 3000 0 0000", fetch_fault, fault_pc, bus.imu_addr, in_handler, epc);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) begin
      push(16'h3000 + 16'(4 * i), mw(16'h3000 + 16'(4 * i)));
      tick();
    end
    halt = 1'b1;
    tick();
    total++;
    if (halted !== 1'b1 || bus.imu_addr !== 16'h3010) begin
      bad++;
      $display("FAIL halt_enter: halted=%b addr=%h, want 1 3010", halted, bus.imu_addr);
    end
    irq = 1'b1;
    tick();
    irq = 1'b0;
    total++;
    if (irq_ack !== 1'b0 || bus.imu_addr !== 16'h3010 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_irq_ignored: ack=%b addr=%h halted=%b, want 0 3010 1", irq_ack, bus.imu_addr, halted);
    end
    step = 1'b1;
    push(16'h3010, mw(16'h3010));
    tick();
    step = 1'b0;
    total++;
    if (bus.imu_addr !== 16'h3014 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_step: addr=%h halted=%b, want 3014 1", bus.imu_addr, halted);
    end
    tick();
    total++;
    if (bus.imu_addr !== 16'h3014) begin
      bad++;
      $display("FAIL halt_after_step: addr got %h want 3014", bus.imu_addr);
    end
    halt = 1'b0;
    tick();
    total++;
    if (halted !== 1'b0 || bus.imu_addr !== 16'h3014) begin
      bad++;
      $display("FAIL halt_exit: halted=%b addr=%h, want 0 3014", halted, bus.imu_addr);
    end
    push(16'h3014, mw(16'h3014));
    tick();
    total++;
    if (bus.imu_addr !== 16'h3018) begin
      bad++;
      $display("FAIL halt_resume: addr got %h want 3018", bus.imu_addr);
    end
  endtask

  task automatic test_wrap();
    br_valid = 1'b1; br_target = 16'hFFFC;
    tick();
    br_valid = 1'b0;
    push(16'hFFFC, mw(16'hFFFC));
    tick();
    total++;
    if (bus.imu_addr !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_addr: got %h want 0000", bus.imu_addr);
    end
    err_drv = 1'b1;
    tick();
    err_drv = 1'b0;
    total++;
    if (fetch_fault !== 1'b1 || fault_pc !== 16'h0000 || bus.imu_addr !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_fault: ff=%b fpc=%h addr=%h, want 1 0000 0000", fetch_fault, fault_pc, bus.imu_addr);
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = 16'h0;
    mret = 1'b0; irq = 1'b0; halt = 1'b0; step = 1'b0; err_drv = 1'b0;
    use_fixed = 1'b0; fixed_word = 32'h0;
    test_reset();
    test_run();
    test_stall_redirect();
    test_irq();
    test_fault();
    test_halt();
    test_wrap();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
